ir_key_ctrl: RTL and testbench

- Sequences the IR receiver's decoded output into key events for the game-console CPU.
- Synchronises the receiver's slow-clock strobes (ir_data_en, ir_repeat_en) into sys_clk and tracks the held key.
- Emits PRESS, REPEAT and RELEASE events, and buffers them in a small FIFO that the CPU peripheral drains with a valid/ready pop.

---
 rtl/ir_key_pkg.sv | 31 +++
 rtl/ir_evt_fifo.sv | 75 +++++++
 rtl/ir_key_ctrl.sv | 184 ++++++++++++++++++
 tb/tb_ir_key_ctrl.sv | 404 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ir_key_pkg.sv
// Shared types and constants for the IR key controller.
// Event encodings, FSM state encodings and the event record layout.
package ir_key_pkg;

    localparam int EVT_W = 10;

    localparam logic [1:0] EVT_PRESS   = 2'b01;
    localparam logic [1:0] EVT_REPEAT  = 2'b10;
    localparam logic [1:0] EVT_RELEASE = 2'b11;

    localparam int S_IDLE = 0;
    localparam int S_HELD = 1;
    localparam int S_SWAP = 2;

    localparam logic [2:0] ST_IDLE = 3'b001;
    localparam logic [2:0] ST_HELD = 3'b010;
    localparam logic [2:0] ST_SWAP = 3'b100;

    typedef struct packed {
        logic [1:0] typ;
        logic [7:0] code;
    } evt_t;

    function automatic evt_t mk_evt(input logic [1:0] t, input logic [7:0] c);
        evt_t e;
        e.typ  = t;
        e.code = c;
        return e;
    endfunction

endpackage

// File: rtl/ir_evt_fifo.sv
// Small event FIFO between the key FSM and the CPU peripheral.
// A push into a full FIFO is accepted only if a pop happens in the same cycle.
module ir_evt_fifo
    import ir_key_pkg::*;
#(
    parameter int FIFO_AW = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               push,
    input  logic [EVT_W-1:0]   push_data,
    input  logic               pop,
    output logic [EVT_W-1:0]   head,
    output logic               full,
    output logic               empty,
    output logic [FIFO_AW:0]   count,
    output logic               drop
);

    localparam int DEPTH = 2 ** FIFO_AW;

    logic [EVT_W-1:0]   mem_q [DEPTH];
    logic [EVT_W-1:0]   mem_d [DEPTH];
    logic [FIFO_AW-1:0] wr_q, wr_d;
    logic [FIFO_AW-1:0] rd_q, rd_d;
    logic [FIFO_AW:0]   cnt_q, cnt_d;
    logic               do_push;
    logic               do_pop;

    assign empty   = (cnt_q == '0);
    assign full    = cnt_q[FIFO_AW];
    assign count   = cnt_q;
    assign head    = mem_q[rd_q];
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign drop    = push & ~do_push;

    // Next-state for storage, pointers and occupancy.
    always_comb begin
        mem_d = mem_q;
        wr_d  = wr_q;
        rd_d  = rd_q;
        cnt_d = cnt_q;
        if (do_push) begin
            mem_d[wr_q] = push_data;
            wr_d        = wr_q + 1'b1;
        end
        if (do_pop) begin
            rd_d = rd_q + 1'b1;
        end
        case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    // FIFO state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            mem_q <= mem_d;
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/ir_key_ctrl.sv
// IR key controller: strobe synchronisers, held-key FSM and event FIFO.
// Turns receiver strobes into PRESS / REPEAT / RELEASE events for the CPU.
module ir_key_ctrl
    import ir_key_pkg::*;
#(
    parameter int HOLD_TIMEOUT = 6000000,
    parameter int REPEAT_SKIP  = 2,
    parameter int FIFO_AW      = 2
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic       enable,
    input  logic       ir_data_en,
    input  logic       ir_repeat_en,
    input  logic [7:0] ir_data,
    output logic       evt_valid,
    output logic [1:0] evt_type,
    output logic [7:0] evt_code,
    input  logic       evt_ready,
    output logic       key_held,
    output logic [7:0] held_code,
    output logic       overflow,
    input  logic       overflow_clr
);

    localparam int             CW        = $clog2(HOLD_TIMEOUT + 1);
    localparam logic [CW-1:0]  HOLD_LAST = CW'(HOLD_TIMEOUT - 1);
    localparam logic [3:0]     SKIP_MAX  = 4'(REPEAT_SKIP);

    logic [2:0]       de_sync_q, de_sync_d;
    logic [2:0]       rep_sync_q, rep_sync_d;
    logic             de_rise_q, de_rise_d;
    logic             rep_rise_q, rep_rise_d;
    logic [2:0]       state_q, state_d;
    logic [CW-1:0]    hold_q, hold_d;
    logic [3:0]       skip_q, skip_d;
    logic [7:0]       held_q, held_d;
    logic [7:0]       pend_q, pend_d;
    logic             ovf_q, ovf_d;
    logic             push;
    evt_t             push_evt;
    logic [EVT_W-1:0] head;
    evt_t             head_evt;
    logic             fifo_full;
    logic             fifo_empty;
    logic [FIFO_AW:0] fifo_count;
    logic             fifo_drop;
    logic             fifo_unused;

    // Synchroniser shift and registered rising-edge pulses.
    always_comb begin
        de_sync_d  = {de_sync_q[1:0], ir_data_en};
        rep_sync_d = {rep_sync_q[1:0], ir_repeat_en};
        de_rise_d  = de_sync_q[1] & ~de_sync_q[2];
        rep_rise_d = rep_sync_q[1] & ~rep_sync_q[2];
    end

    // Held-key FSM; at most one event pushed per cycle.
    always_comb begin
        state_d  = state_q;
        hold_d   = hold_q;
        skip_d   = skip_q;
        held_d   = held_q;
        pend_d   = pend_q;
        push     = 1'b0;
        push_evt = mk_evt(EVT_PRESS, 8'h00);
        if (!enable) begin
            if (state_q != ST_IDLE) begin
                push     = 1'b1;
                push_evt = mk_evt(EVT_RELEASE, held_q);
            end
            state_d = ST_IDLE;
            hold_d  = '0;
            skip_d  = '0;
        end else begin
            unique case (1'b1)
                state_q[S_IDLE]: begin
                    if (de_rise_q) begin
                        push     = 1'b1;
                        push_evt = mk_evt(EVT_PRESS, ir_data);
                        held_d   = ir_data;
                        hold_d   = '0;
                        skip_d   = '0;
                        state_d  = ST_HELD;
                    end
                end
                state_q[S_HELD]: begin
                    hold_d = hold_q + 1'b1;
                    if (de_rise_q) begin
                        if (ir_data == held_q) begin
                            hold_d = '0;
                        end else begin
                            push     = 1'b1;
                            push_evt = mk_evt(EVT_RELEASE, held_q);
                            pend_d   = ir_data;
                            state_d  = ST_SWAP;
                        end
                    end else if (rep_rise_q) begin
                        hold_d = '0;
                        if (skip_q < SKIP_MAX) begin
                            skip_d = skip_q + 1'b1;
                        end else begin
                            push     = 1'b1;
                            push_evt = mk_evt(EVT_REPEAT, held_q);
                        end
                    end else if (hold_q == HOLD_LAST) begin
                        push     = 1'b1;
                        push_evt = mk_evt(EVT_RELEASE, held_q);
                        hold_d   = '0;
                        state_d  = ST_IDLE;
                    end
                end
                state_q[S_SWAP]: begin
                    push     = 1'b1;
                    push_evt = mk_evt(EVT_PRESS, pend_q);
                    held_d   = pend_q;
                    hold_d   = '0;
                    skip_d   = '0;
                    state_d  = ST_HELD;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // Sticky overflow; a drop wins over a same-cycle clear.
    always_comb begin
        ovf_d = (ovf_q & ~overflow_clr) | fifo_drop;
    end

    // Controller state registers.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            de_sync_q  <= '0;
            rep_sync_q <= '0;
            de_rise_q  <= 1'b0;
            rep_rise_q <= 1'b0;
            state_q    <= ST_IDLE;
            hold_q     <= '0;
            skip_q     <= '0;
            held_q     <= '0;
            pend_q     <= '0;
            ovf_q      <= 1'b0;
        end else begin
            de_sync_q  <= de_sync_d;
            rep_sync_q <= rep_sync_d;
            de_rise_q  <= de_rise_d;
            rep_rise_q <= rep_rise_d;
            state_q    <= state_d;
            hold_q     <= hold_d;
            skip_q     <= skip_d;
            held_q     <= held_d;
            pend_q     <= pend_d;
            ovf_q      <= ovf_d;
        end
    end

    ir_evt_fifo #(
        .FIFO_AW (FIFO_AW)
    ) u_fifo (
        .clk       (sys_clk),
        .rst_n     (sys_rst_n),
        .push      (push),
        .push_data (push_evt),
        .pop       (evt_ready),
        .head      (head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count),
        .drop      (fifo_drop)
    );

    assign fifo_unused = ^{fifo_full, fifo_count};
    assign head_evt    = evt_t'(head);
    assign evt_valid   = ~fifo_empty;
    assign evt_type    = head_evt.typ;
    assign evt_code    = head_evt.code;
    assign key_held    = state_q[S_HELD];
    assign held_code   = held_q;
    assign overflow    = ovf_q;

endmodule

// File: tb/tb_ir_key_ctrl.sv
// Directed bench for ir_key_ctrl.
// Each task drives one scenario and checks its own expected values.
module tb_ir_key_ctrl;

    logic       sys_clk = 1'b0;
    logic       sys_rst_n = 1'b0;
    logic       enable = 1'b1;
    logic       ir_data_en = 1'b0;
    logic       ir_repeat_en = 1'b0;
    logic [7:0] ir_data = 8'h00;
    logic       evt_valid;
    logic [1:0] evt_type;
    logic [7:0] evt_code;
    logic       evt_ready = 1'b0;
    logic       key_held;
    logic [7:0] held_code;
    logic       overflow;
    logic       overflow_clr = 1'b0;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    logic       pv;
    logic [1:0] pt;
    logic [7:0] pc;

    ir_key_ctrl #(
        .HOLD_TIMEOUT (1000),
        .REPEAT_SKIP  (2),
        .FIFO_AW      (2)
    ) dut (
        .sys_clk      (sys_clk),
        .sys_rst_n    (sys_rst_n),
        .enable       (enable),
        .ir_data_en   (ir_data_en),
        .ir_repeat_en (ir_repeat_en),
        .ir_data      (ir_data),
        .evt_valid    (evt_valid),
        .evt_type     (evt_type),
        .evt_code     (evt_code),
        .evt_ready    (evt_ready),
        .key_held     (key_held),
        .held_code    (held_code),
        .overflow     (overflow),
        .overflow_clr (overflow_clr)
    );

    always #5 sys_clk = ~sys_clk;

    always @(posedge sys_clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog expired at cyc=%0d", cyc);
        $fatal(1);
    end

    task automatic wait_cyc(input int t);
        while (cyc < t) @(negedge sys_clk);
    endtask

    task automatic apply_reset();
        @(negedge sys_clk);
        sys_rst_n    = 1'b0;
        enable       = 1'b1;
        ir_data_en   = 1'b0;
        ir_repeat_en = 1'b0;
        ir_data      = 8'h00;
        evt_ready    = 1'b0;
        overflow_clr = 1'b0;
        repeat (3) @(negedge sys_clk);
        sys_rst_n = 1'b1;
    endtask

    task automatic de_on(input logic [7:0] c, output int n);
        @(negedge sys_clk);
        ir_data    = c;
        ir_data_en = 1'b1;
        n          = cyc;
    endtask

    task automatic strobe_off();
        @(negedge sys_clk);
        ir_data_en   = 1'b0;
        ir_repeat_en = 1'b0;
        repeat (4) @(negedge sys_clk);
    endtask

    task automatic pop_evt(output logic v, output logic [1:0] t, output logic [7:0] c);
        v         = evt_valid;
        t         = evt_type;
        c         = evt_code;
        evt_ready = 1'b1;
        @(negedge sys_clk);
        evt_ready = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        checks++;
        if (evt_valid !== 1'b0 || evt_type !== 2'b00 || evt_code !== 8'h00) begin
            failures++;
            $display("FAIL reset_evt got=%b/%b/%h exp=0/00/00", evt_valid, evt_type, evt_code);
        end
        checks++;
        if (key_held !== 1'b0 || held_code !== 8'h00) begin
            failures++;
            $display("FAIL reset_key got=%b/%h exp=0/00", key_held, held_code);
        end
        checks++;
        if (overflow !== 1'b0) begin
            failures++;
            $display("FAIL reset_ovf got=%b exp=0", overflow);
        end
    endtask

    task automatic test_press();
        int n;
        de_on(8'h45, n);
        wait_cyc(n + 3);
        checks++;
        if (evt_valid !== 1'b0) begin
            failures++;
            $display("FAIL press_early got=%b exp=0", evt_valid);
        end
        wait_cyc(n + 4);
        checks++;
        if (evt_valid !== 1'b1 || evt_type !== 2'b01 || evt_code !== 8'h45) begin
            failures++;
            $display("FAIL press_evt got=%b/%b/%h exp=1/01/45", evt_valid, evt_type, evt_code);
        end
        checks++;
        if (key_held !== 1'b1 || held_code !== 8'h45) begin
            failures++;
            $display("FAIL press_held got=%b/%h exp=1/45", key_held, held_code);
        end
        pop_evt(pv, pt, pc);
        strobe_off();
        wait_cyc(n + 1003);
        checks++;
        if (key_held !== 1'b1 || evt_valid !== 1'b0) begin
            failures++;
            $display("FAIL press_pre_timeout got=%b/%b exp=1/0", key_held, evt_valid);
        end
        wait_cyc(n + 1004);
        checks++;
        if (evt_valid !== 1'b1 || evt_type !== 2'b11 || evt_code !== 8'h45 || key_held !== 1'b0) begin
            failures++;
            $display("FAIL press_release got=%b/%b/%h/%b exp=1/11/45/0",
                     evt_valid, evt_type, evt_code, key_held);
        end
        pop_evt(pv, pt, pc);
    endtask

    task automatic test_repeat();
        int n;
        logic [1:0] et [4];
        et = '{2'b01, 2'b10, 2'b10, 2'b11};
        de_on(8'h18, n);
        wait_cyc(n + 4);
        strobe_off();
        for (int k = 0; k < 4; k++) begin
            wait_cyc(n + 100 + 500 * k);
            ir_repeat_en = 1'b1;
            wait_cyc(n + 106 + 500 * k);
            ir_repeat_en = 1'b0;
        end
        wait_cyc(n + 2603);
        checks++;
        if (key_held !== 1'b1) begin
            failures++;
            $display("FAIL repeat_hold got=%b exp=1", key_held);
        end
        wait_cyc(n + 2604);
        checks++;
        if (key_held !== 1'b0) begin
            failures++;
            $display("FAIL repeat_timeout got=%b exp=0", key_held);
        end
        for (int i = 0; i < 4; i++) begin
            pop_evt(pv, pt, pc);
            checks++;
            if (pv !== 1'b1 || pt !== et[i] || pc !== 8'h18) begin
                failures++;
                $display("FAIL repeat_seq[%0d] got=%b/%b/%h exp=1/%b/18", i, pv, pt, pc, et[i]);
            end
        end
        checks++;
        if (evt_valid !== 1'b0 || overflow !== 1'b0) begin
            failures++;
            $display("FAIL repeat_tail got=%b/%b exp=0/0", evt_valid, overflow);
        end
    endtask

    task automatic test_swap();
        int n;
        int m;
        de_on(8'h45, n);
        wait_cyc(n + 4);
        pop_evt(pv, pt, pc);
        strobe_off();
        de_on(8'h46, m);
        wait_cyc(m + 4);
        checks++;
        if (evt_valid !== 1'b1 || evt_type !== 2'b11 || evt_code !== 8'h45) begin
            failures++;
            $display("FAIL swap_release got=%b/%b/%h exp=1/11/45", evt_valid, evt_type, evt_code);
        end
        wait_cyc(m + 5);
        checks++;
        if (key_held !== 1'b1 || held_code !== 8'h46) begin
            failures++;
            $display("FAIL swap_held got=%b/%h exp=1/46", key_held, held_code);
        end
        pop_evt(pv, pt, pc);
        pop_evt(pv, pt, pc);
        checks++;
        if (pv !== 1'b1 || pt !== 2'b01 || pc !== 8'h46) begin
            failures++;
            $display("FAIL swap_press got=%b/%b/%h exp=1/01/46", pv, pt, pc);
        end
        checks++;
        if (evt_valid !== 1'b0) begin
            failures++;
            $display("FAIL swap_empty got=%b exp=0", evt_valid);
        end
        strobe_off();
    endtask

    task automatic test_disable();
        int d;
        int x;
        @(negedge sys_clk);
        enable = 1'b0;
        d = cyc;
        wait_cyc(d + 1);
        checks++;
        if (key_held !== 1'b0 || evt_valid !== 1'b1 || evt_type !== 2'b11 || evt_code !== 8'h46) begin
            failures++;
            $display("FAIL disable_release got=%b/%b/%b/%h exp=0/1/11/46",
                     key_held, evt_valid, evt_type, evt_code);
        end
        pop_evt(pv, pt, pc);
        checks++;
        if (evt_valid !== 1'b0) begin
            failures++;
            $display("FAIL disable_single got=%b exp=0", evt_valid);
        end
        de_on(8'h50, x);
        wait_cyc(x + 6);
        checks++;
        if (evt_valid !== 1'b0 || key_held !== 1'b0) begin
            failures++;
            $display("FAIL disable_ignore got=%b/%b exp=0/0", evt_valid, key_held);
        end
        strobe_off();
        enable = 1'b1;
    endtask

    task automatic test_overflow();
        int n;
        logic [1:0] et [4];
        logic [7:0] ec [4];
        et = '{2'b01, 2'b11, 2'b01, 2'b11};
        ec = '{8'h10, 8'h10, 8'h11, 8'h11};
        apply_reset();
        de_on(8'h10, n);
        wait_cyc(n + 4);
        strobe_off();
        de_on(8'h11, n);
        wait_cyc(n + 5);
        strobe_off();
        de_on(8'h12, n);
        wait_cyc(n + 5);
        checks++;
        if (overflow !== 1'b1 || held_code !== 8'h12) begin
            failures++;
            $display("FAIL ovf_set got=%b/%h exp=1/12", overflow, held_code);
        end
        for (int i = 0; i < 4; i++) begin
            pop_evt(pv, pt, pc);
            checks++;
            if (pv !== 1'b1 || pt !== et[i] || pc !== ec[i]) begin
                failures++;
                $display("FAIL ovf_seq[%0d] got=%b/%b/%h exp=1/%b/%h", i, pv, pt, pc, et[i], ec[i]);
            end
        end
        checks++;
        if (evt_valid !== 1'b0 || overflow !== 1'b1) begin
            failures++;
            $display("FAIL ovf_drained got=%b/%b exp=0/1", evt_valid, overflow);
        end
        overflow_clr = 1'b1;
        @(negedge sys_clk);
        overflow_clr = 1'b0;
        checks++;
        if (overflow !== 1'b0) begin
            failures++;
            $display("FAIL ovf_clr got=%b exp=0", overflow);
        end
        strobe_off();
    endtask

    task automatic test_simultaneous();
        int n;
        int s;
        logic [1:0] et [4];
        logic [7:0] ec [4];
        et = '{2'b11, 2'b01, 2'b11, 2'b01};
        ec = '{8'h20, 8'h21, 8'h21, 8'h22};
        apply_reset();
        de_on(8'h20, n);
        wait_cyc(n + 4);
        strobe_off();
        de_on(8'h21, n);
        wait_cyc(n + 5);
        strobe_off();
        de_on(8'h22, s);
        wait_cyc(s + 4);
        evt_ready = 1'b1;
        wait_cyc(s + 5);
        evt_ready = 1'b0;
        checks++;
        if (overflow !== 1'b0) begin
            failures++;
            $display("FAIL simul_ovf got=%b exp=0", overflow);
        end
        for (int i = 0; i < 4; i++) begin
            pop_evt(pv, pt, pc);
            checks++;
            if (pv !== 1'b1 || pt !== et[i] || pc !== ec[i]) begin
                failures++;
                $display("FAIL simul_seq[%0d] got=%b/%b/%h exp=1/%b/%h", i, pv, pt, pc, et[i], ec[i]);
            end
        end
        checks++;
        if (evt_valid !== 1'b0) begin
            failures++;
            $display("FAIL simul_count got=%b exp=0", evt_valid);
        end
        strobe_off();
        wait_cyc(s + 1001);
        ir_repeat_en = 1'b1;
        wait_cyc(s + 1005);
        checks++;
        if (key_held !== 1'b1 || evt_valid !== 1'b0) begin
            failures++;
            $display("FAIL simul_rep_vs_timeout got=%b/%b exp=1/0", key_held, evt_valid);
        end
        wait_cyc(s + 1008);
        ir_repeat_en = 1'b0;
        wait_cyc(s + 2005);
        checks++;
        if (key_held !== 1'b0 || evt_valid !== 1'b1 || evt_type !== 2'b11 || evt_code !== 8'h22) begin
            failures++;
            $display("FAIL simul_late_release got=%b/%b/%b/%h exp=0/1/11/22",
                     key_held, evt_valid, evt_type, evt_code);
        end
    endtask

    task automatic test_reset_mid();
        int n;
        apply_reset();
        de_on(8'h30, n);
        wait_cyc(n + 4);
        strobe_off();
        de_on(8'h31, n);
        wait_cyc(n + 5);
        strobe_off();
        de_on(8'h32, n);
        wait_cyc(n + 5);
        pop_evt(pv, pt, pc);
        checks++;
        if (evt_valid !== 1'b1 || overflow !== 1'b1) begin
            failures++;
            $display("FAIL rstmid_pre got=%b/%b exp=1/1", evt_valid, overflow);
        end
        #2;
        sys_rst_n = 1'b0;
        #1;
        checks++;
        if (evt_valid !== 1'b0 || overflow !== 1'b0 || key_held !== 1'b0 || evt_code !== 8'h00) begin
            failures++;
            $display("FAIL rstmid_clear got=%b/%b/%b/%h exp=0/0/0/00",
                     evt_valid, overflow, key_held, evt_code);
        end
        apply_reset();
    endtask

    initial begin
        test_reset();
        test_press();
        test_repeat();
        test_swap();
        test_disable();
        test_overflow();
        test_simultaneous();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
